// File: rtl/intersection_pkg.sv
// Shared types and constants for the two-approach intersection controller.
// The state encoding doubles as the externally visible phase code.
package intersection_pkg;

   typedef enum logic [2:0] {
      ALLRED_NS = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      WALK      = 3'd3,
      ALLRED_EW = 3'd4,
      EW_GREEN  = 3'd5,
      EW_YELLOW = 3'd6
   } state_t;

   // Lamp patterns are packed as {red, yellow, green}.
   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Status and pedestrian handshake bundle between the controller and its environment.
interface intersection_controller_if;
   // ped_req is a level or pulse sampled every clk; ped_ack pulses for exactly one
   // cycle when the WALK that serves all outstanding requests begins.
   logic       enable;
   logic       ped_req;
   logic       ped_ack;
   logic       walk;
   logic       ns_red;
   logic       ns_yellow;
   logic       ns_green;
   logic       ew_red;
   logic       ew_yellow;
   logic       ew_green;
   logic [2:0] phase;

   modport master (
      output enable, ped_req,
      input  ped_ack, walk, ns_red, ns_yellow, ns_green,
             ew_red, ew_yellow, ew_green, phase
   );

   modport slave (
      input  enable, ped_req,
      output ped_ack, walk, ns_red, ns_yellow, ns_green,
             ew_red, ew_yellow, ew_green, phase
   );
endinterface

// File: rtl/intersection_controller_phase_timer.sv
// Phase duration counter: counts enabled cycles 0..limit-1 and flags the last one.
// The limit port is one bit wider than the count so a duration of 2**W still fits.
module phase_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W:0]   limit,
   output logic         done
);

   localparam int LW = W + 1;

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign done = enable && ({1'b0, count_q} == (limit - LW'(1)));

   always_comb begin
      count_d = count_q;
      if (clear || done) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/intersection_controller.sv
// Intersection sequencer: NS and EW approaches with all-red clearance and an
// optional pedestrian WALK after either yellow, served by a latched request.
module intersection_controller
   import intersection_pkg::*;
#(
   parameter int GREEN_CYCLES  = 20,
   parameter int YELLOW_CYCLES = 7,
   parameter int ALLRED_CYCLES = 5,
   parameter int WALK_CYCLES   = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   intersection_controller_if.slave  bus
);

   localparam int MAXC = max4(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES, WALK_CYCLES);
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int LW   = TW + 1;

   state_t      state_q, state_d;
   logic        ped_pending_q, ped_pending_d;
   logic        next_dir_q, next_dir_d;
   logic        ped_ack_q, ped_ack_d;
   logic [TW:0] limit;
   logic        illegal;
   logic        done;
   logic        enter_walk;
   logic [2:0]  ns_lamp;
   logic [2:0]  ew_lamp;

   always_comb begin
      limit   = LW'(ALLRED_CYCLES);
      illegal = 1'b0;
      case (state_q)
         ALLRED_NS, ALLRED_EW: limit = LW'(ALLRED_CYCLES);
         NS_GREEN,  EW_GREEN:  limit = LW'(GREEN_CYCLES);
         NS_YELLOW, EW_YELLOW: limit = LW'(YELLOW_CYCLES);
         WALK:                 limit = LW'(WALK_CYCLES);
         default:              illegal = 1'b1;
      endcase
   end

   phase_timer #(.W(TW)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (illegal),
      .enable (bus.enable),
      .limit  (limit),
      .done   (done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ALLRED_NS;
         ped_pending_q <= 1'b0;
         next_dir_q    <= DIR_NS;
         ped_ack_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ped_pending_q <= ped_pending_d;
         next_dir_q    <= next_dir_d;
         ped_ack_q     <= ped_ack_d;
      end
   end

   // WALK is only taken if the request was already latched in the yellow's last cycle.
   always_comb begin
      state_d    = state_q;
      next_dir_d = next_dir_q;
      if (illegal) begin
         state_d = ALLRED_NS;
      end else if (done) begin
         case (state_q)
            ALLRED_NS: state_d = NS_GREEN;
            NS_GREEN:  state_d = NS_YELLOW;
            NS_YELLOW: begin
               if (ped_pending_q) begin
                  state_d    = WALK;
                  next_dir_d = DIR_EW;
               end else begin
                  state_d = ALLRED_EW;
               end
            end
            WALK:      state_d = (next_dir_q == DIR_EW) ? ALLRED_EW : ALLRED_NS;
            ALLRED_EW: state_d = EW_GREEN;
            EW_GREEN:  state_d = EW_YELLOW;
            EW_YELLOW: begin
               if (ped_pending_q) begin
                  state_d    = WALK;
                  next_dir_d = DIR_NS;
               end else begin
                  state_d = ALLRED_NS;
               end
            end
            default:   state_d = ALLRED_NS;
         endcase
      end
   end

   assign enter_walk = (state_d == WALK) && (state_q != WALK);

   always_comb begin
      ped_pending_d = ped_pending_q;
      if (enter_walk) begin
         ped_pending_d = 1'b0;
      end else if (bus.ped_req && (state_q != WALK)) begin
         ped_pending_d = 1'b1;
      end
      ped_ack_d = enter_walk;
   end

   always_comb begin
      ns_lamp = LAMP_RED;
      ew_lamp = LAMP_RED;
      case (state_q)
         NS_GREEN:  ns_lamp = LAMP_GREEN;
         NS_YELLOW: ns_lamp = LAMP_YELLOW;
         EW_GREEN:  ew_lamp = LAMP_GREEN;
         EW_YELLOW: ew_lamp = LAMP_YELLOW;
         default: begin
            ns_lamp = LAMP_RED;
            ew_lamp = LAMP_RED;
         end
      endcase
   end

   assign {bus.ns_red, bus.ns_yellow, bus.ns_green} = ns_lamp;
   assign {bus.ew_red, bus.ew_yellow, bus.ew_green} = ew_lamp;
   assign bus.walk    = (state_q == WALK);
   assign bus.ped_ack = ped_ack_q;
   assign bus.phase   = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: directed scenarios with literal
// timing points, a phase/duration model compared every cycle, and invariant checks.
module tb_intersection_controller;
   import intersection_pkg::*;

   localparam int G = 20;
   localparam int Y = 7;
   localparam int A = 5;
   localparam int W = 10;
   localparam int BOUND = 2 * (G + Y + A) + W;

   localparam logic [6:0] P_ALLRED = 7'b100_100_0;
   localparam logic [6:0] P_NSG    = 7'b001_100_0;
   localparam logic [6:0] P_NSY    = 7'b010_100_0;
   localparam logic [6:0] P_EWG    = 7'b100_001_0;
   localparam logic [6:0] P_EWY    = 7'b100_010_0;
   localparam logic [6:0] P_WALK   = 7'b100_100_1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   intersection_controller_if bus();

   intersection_controller #(
      .GREEN_CYCLES  (G),
      .YELLOW_CYCLES (Y),
      .ALLRED_CYCLES (A),
      .WALK_CYCLES   (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [6:0] dut_pattern();
      return {bus.ns_red, bus.ns_yellow, bus.ns_green,
              bus.ew_red, bus.ew_yellow, bus.ew_green, bus.walk};
   endfunction

   // ---------------- behavioural model ----------------
   state_t m_state;
   int     m_left;
   bit     m_pend;
   bit     m_ret_ew;
   bit     m_ack;
   bit     age_on;
   int     age;

   function automatic int dur(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   return G;
         NS_YELLOW, EW_YELLOW: return Y;
         WALK:                 return W;
         default:              return A;
      endcase
   endfunction

   function automatic logic [6:0] model_pattern();
      case (m_state)
         NS_GREEN:  return P_NSG;
         NS_YELLOW: return P_NSY;
         EW_GREEN:  return P_EWG;
         EW_YELLOW: return P_EWY;
         WALK:      return P_WALK;
         default:   return P_ALLRED;
      endcase
   endfunction

   task automatic model_reset();
      m_state  = ALLRED_NS;
      m_left   = A;
      m_pend   = 1'b0;
      m_ret_ew = 1'b0;
      m_ack    = 1'b0;
      age_on   = 1'b0;
      age      = 0;
   endtask

   task automatic model_step(input bit en, input bit req);
      state_t nxt;
      bit     enter;
      nxt   = m_state;
      enter = 1'b0;
      if (en) begin
         m_left--;
         if (m_left == 0) begin
            case (m_state)
               ALLRED_NS: nxt = NS_GREEN;
               NS_GREEN:  nxt = NS_YELLOW;
               NS_YELLOW: if (m_pend) begin nxt = WALK; enter = 1'b1; m_ret_ew = 1'b1; end
                          else nxt = ALLRED_EW;
               WALK:      nxt = m_ret_ew ? ALLRED_EW : ALLRED_NS;
               ALLRED_EW: nxt = EW_GREEN;
               EW_GREEN:  nxt = EW_YELLOW;
               EW_YELLOW: if (m_pend) begin nxt = WALK; enter = 1'b1; m_ret_ew = 1'b0; end
                          else nxt = ALLRED_NS;
               default:   nxt = ALLRED_NS;
            endcase
            m_left = dur(nxt);
         end
      end
      if (req && (m_state != WALK) && !age_on && !enter) begin
         age_on = 1'b1;
         age    = 0;
      end
      if (age_on && en) age++;
      if (enter && age_on) begin
         check("ack_latency", {31'd0, age <= BOUND}, 32'd1);
         age_on = 1'b0;
      end else if (age_on && age > BOUND) begin
         check("ack_latency_expired", {31'd0, age <= BOUND}, 32'd1);
         age_on = 1'b0;
      end
      if (enter) m_pend = 1'b0;
      else if (req && (m_state != WALK)) m_pend = 1'b1;
      m_ack   = enter;
      m_state = nxt;
   endtask

   // Compare process: one sample per cycle, just before the edge that consumes it.
   initial begin
      logic [11:0] act_v, exp_v;
      bit inv_ok;
      int ns_cnt, ew_cnt;
      model_reset();
      forever begin
         @(negedge clk);
         if (reset) model_reset();
         act_v = {dut_pattern(), bus.ped_ack, bus.phase, 1'b0};
         exp_v = {model_pattern(), m_ack, m_state, 1'b0};
         check("cycle_outputs", {20'd0, act_v}, {20'd0, exp_v});
         ns_cnt = int'(bus.ns_red) + int'(bus.ns_yellow) + int'(bus.ns_green);
         ew_cnt = int'(bus.ew_red) + int'(bus.ew_yellow) + int'(bus.ew_green);
         inv_ok = (ns_cnt == 1) && (ew_cnt == 1) && (bus.ns_red || bus.ew_red) &&
                  !(bus.walk && !(bus.ns_red && bus.ew_red));
         check("invariants", {31'd0, inv_ok}, 32'd1);
         if (!reset) model_step(bus.enable, bus.ped_req);
      end
   end

   // ---------------- driver ----------------
   task automatic start_scn();
      reset       = 1'b1;
      bus.enable  = 1'b0;
      bus.ped_req = 1'b0;
      #1;
      check("reset_pattern", {25'd0, dut_pattern()}, {25'd0, P_ALLRED});
      check("reset_ack", {31'd0, bus.ped_ack}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic drive(input bit en, input bit req);
      bus.enable  = en;
      bus.ped_req = req;
      @(negedge clk);
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acks;
      bus.enable  = 1'b0;
      bus.ped_req = 1'b0;

      // 1: free run, no requests
      start_scn();
      for (int k = 0; k < 130; k++) begin
         drive(1'b1, 1'b0);
         case (k)
            0, 4, 32, 36, 64, 68: check($sformatf("s1_allred_c%0d", k), {25'd0, dut_pattern()}, {25'd0, P_ALLRED});
            5, 24, 69:            check($sformatf("s1_nsg_c%0d", k), {25'd0, dut_pattern()}, {25'd0, P_NSG});
            25, 31:               check($sformatf("s1_nsy_c%0d", k), {25'd0, dut_pattern()}, {25'd0, P_NSY});
            37, 56:               check($sformatf("s1_ewg_c%0d", k), {25'd0, dut_pattern()}, {25'd0, P_EWG});
            57, 63:               check($sformatf("s1_ewy_c%0d", k), {25'd0, dut_pattern()}, {25'd0, P_EWY});
            default: ;
         endcase
         next_cycle();
      end

      // 2: single request pulse
      start_scn();
      for (int k = 0; k < 60; k++) begin
         drive(1'b1, k == 10);
         case (k)
            31: check("s2_nsy_c31", {25'd0, dut_pattern()}, {25'd0, P_NSY});
            32: begin
               check("s2_walk_c32", {25'd0, dut_pattern()}, {25'd0, P_WALK});
               check("s2_ack_c32", {31'd0, bus.ped_ack}, 32'd1);
            end
            33: check("s2_ack_c33", {31'd0, bus.ped_ack}, 32'd0);
            41: check("s2_walk_c41", {25'd0, dut_pattern()}, {25'd0, P_WALK});
            42, 46: check($sformatf("s2_allred_c%0d", k), {25'd0, dut_pattern()}, {25'd0, P_ALLRED});
            47: check("s2_ewg_c47", {25'd0, dut_pattern()}, {25'd0, P_EWG});
            default: ;
         endcase
         next_cycle();
      end

      // 3: repeated and held requests collapse into one WALK
      start_scn();
      acks = 0;
      for (int k = 0; k < 110; k++) begin
         drive(1'b1, (k == 10) || (k == 20) || (k >= 28 && k <= 35));
         if (bus.ped_ack) acks++;
         case (k)
            32: check("s3_ack_c32", {31'd0, bus.ped_ack}, 32'd1);
            73: check("s3_ewy_c73", {25'd0, dut_pattern()}, {25'd0, P_EWY});
            74: check("s3_no_walk_c74", {25'd0, dut_pattern()}, {25'd0, P_ALLRED});
            79: check("s3_nsg_c79", {25'd0, dut_pattern()}, {25'd0, P_NSG});
            default: ;
         endcase
         next_cycle();
      end
      check("s3_ack_count", acks, 32'd1);

      // 4: freeze during NS green
      start_scn();
      for (int k = 0; k < 50; k++) begin
         drive(!(k >= 10 && k <= 24), 1'b0);
         case (k)
            15: check("s4_phase_frozen", {29'd0, bus.phase}, {29'd0, NS_GREEN});
            39: check("s4_nsg_c39", {25'd0, dut_pattern()}, {25'd0, P_NSG});
            40: check("s4_nsy_c40", {25'd0, dut_pattern()}, {25'd0, P_NSY});
            default: ;
         endcase
         next_cycle();
      end

      // 5: asynchronous reset mid EW green, then restart timing
      start_scn();
      for (int k = 0; k <= 45; k++) begin
         drive(1'b1, 1'b0);
         if (k == 45) check("s5_ewg_c45", {25'd0, dut_pattern()}, {25'd0, P_EWG});
         if (k < 45) next_cycle();
      end
      reset = 1'b1;
      #1;
      check("s5_async_lamps", {25'd0, dut_pattern()}, {25'd0, P_ALLRED});
      check("s5_async_phase", {29'd0, bus.phase}, {29'd0, ALLRED_NS});
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         drive(1'b1, 1'b0);
         case (k)
            4:  check("s5_allred_c4", {25'd0, dut_pattern()}, {25'd0, P_ALLRED});
            5:  check("s5_nsg_c5", {25'd0, dut_pattern()}, {25'd0, P_NSG});
            25: check("s5_nsy_c25", {25'd0, dut_pattern()}, {25'd0, P_NSY});
            37: check("s5_ewg_c37", {25'd0, dut_pattern()}, {25'd0, P_EWG});
            default: ;
         endcase
         next_cycle();
      end

      // 6: random enable and requests
      start_scn();
      for (int k = 0; k < 10000; k++) begin
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
